// File: rtl/median_pkg.sv
// median_pkg: feeder FSM encoding and default parameters shared by
// median_feeder and its input buffer.
`ifndef DATA_LENGTH
`define DATA_LENGTH 16
`endif

package median_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } feed_state_t;

    localparam int DATA_WIDTH_DEF = `DATA_LENGTH;
    localparam int WINDOW_DEF     = 20;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int MED_LAT_DEF    = 2;

    localparam logic [15:0] UCNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two depth synchronous FIFO with a show-ahead head.
// Pointers wrap naturally; occupancy is one bit wider than the pointers.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push}
                           - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/median_feeder.sv
// median_feeder: paces samples into a two-phase median filter, qualifies its medians.
// Define MEDIAN_FEEDER_UNDERRUN_CNT_EN to add the saturating underrun counter.
module median_feeder
    import median_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int WINDOW     = WINDOW_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int MED_LAT    = MED_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] x_out,
    output logic                  phase,
    input  logic [DATA_WIDTH-1:0] med_in,
    output logic                  med_valid,
    output logic [DATA_WIDTH-1:0] med_data,
    output logic                  underrun,
    output logic [15:0]           underrun_cnt
);

    localparam int SW = $clog2(WINDOW + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(WINDOW - 1);

    logic                  phase_q;
    logic [DATA_WIDTH-1:0] x_q;
    logic [DATA_WIDTH-1:0] med_q;
    logic [DATA_WIDTH-1:0] head;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  under_d;
    logic                  under_q;
    feed_state_t           state_q;
    feed_state_t           state_d;
    logic [SW-1:0]         slot_q;
    logic [SW-1:0]         slot_d;
    logic                  issue;
    logic [MED_LAT:1]      vld_q;
    logic [MED_LAT:0]      vld_all;

    assign push     = in_valid && !full;
    assign in_ready = !full;
    assign pop      = phase_q && !empty;
    assign under_d  = phase_q && empty;

    sync_fifo #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .pop_i  (pop),
        .wdata_i(in_data),
        .rdata_o(head),
        .full_o (full),
        .empty_o(empty)
    );

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (pop && slot_q != '1) begin
            slot_d = slot_q + SW'(1);
        end
        unique case (state_q)
            FILL: if (pop && slot_q == SLOT_LAST) state_d = RUN;
            RUN:  state_d = RUN;
            default: state_d = FILL;
        endcase
        // The slot that completes the window already counts as RUN.
        issue = pop && (state_d == RUN);
    end

    assign vld_all = {vld_q, issue};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= 1'b0;
            x_q     <= '0;
            med_q   <= '0;
            under_q <= 1'b0;
            state_q <= FILL;
            slot_q  <= '0;
            vld_q   <= '0;
        end else begin
            phase_q <= !phase_q;
            under_q <= under_d;
            state_q <= state_d;
            slot_q  <= slot_d;
            vld_q   <= vld_all[MED_LAT-1:0];
            if (pop) begin
                x_q <= head;
            end
            if (vld_all[MED_LAT-1]) begin
                med_q <= med_in;
            end
        end
    end

`ifdef MEDIAN_FEEDER_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ucnt_q <= '0;
        end else if (under_d && ucnt_q != UCNT_MAX) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underrun_cnt = ucnt_q;
`else
    assign underrun_cnt = '0;
`endif

    assign phase     = phase_q;
    assign x_out     = x_q;
    assign underrun  = under_q;
    assign med_valid = vld_all[MED_LAT];
    assign med_data  = med_q;

endmodule

// File: tb/tb_median_feeder.sv
// tb_median_feeder: vector table, directed sequences and random traffic
// checked against a queue-based model of the feeder.
module tb_median_feeder;

    localparam int DW  = 16;
    localparam int WIN = 20;
    localparam int FD  = 4;
    localparam int ML  = 2;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic [DW-1:0] med_in   = '0;
    logic          in_ready;
    logic [DW-1:0] x_out;
    logic          phase;
    logic          med_valid;
    logic [DW-1:0] med_data;
    logic          underrun;
    logic [15:0]   underrun_cnt;

    always #5 clk = ~clk;

    median_feeder #(
        .DATA_WIDTH(DW),
        .WINDOW    (WIN),
        .FIFO_DEPTH(FD),
        .MED_LAT   (ML)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .x_out       (x_out),
        .phase       (phase),
        .med_in      (med_in),
        .med_valid   (med_valid),
        .med_data    (med_data),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] val;
    } med_t;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          ph;
        logic [DW-1:0] x;
        logic          rdy;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;
    int unsigned e = 0;

    logic [DW-1:0] mq[$];
    med_t          dq[$];
    logic          m_phase;
    logic          m_under;
    logic [DW-1:0] m_x;
    logic [15:0]   m_ucnt;
    int            m_issued;

    int            n_medv;
    int            n_under_seen;
    bit            collect = 1'b0;
    logic [DW-1:0] seen[$];
    logic [DW-1:0] acc_q[$];

    function automatic logic [DW-1:0] f(input int unsigned k);
        return DW'(k * 37 + 5);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)",
                      nm, act, exp, e);
    endtask

    task automatic model_reset();
        mq.delete();
        dq.delete();
        m_phase  = 1'b0;
        m_under  = 1'b0;
        m_x      = '0;
        m_ucnt   = '0;
        m_issued = 0;
    endtask

    task automatic model_edge();
        bit rdy = mq.size() < FD;
        m_under = 1'b0;
        if (m_phase) begin
            if (mq.size() > 0) begin
                m_x = mq.pop_front();
                m_issued++;
                if (m_issued >= WIN)
                    dq.push_back('{due: e + ML - 1, val: f(e + ML - 2)});
            end else begin
                m_under = 1'b1;
`ifdef MEDIAN_FEEDER_UNDERRUN_CNT_EN
                if (m_ucnt != 16'hFFFF) m_ucnt++;
`endif
            end
        end
        if (in_valid && rdy) mq.push_back(in_data);
        m_phase = !m_phase;
    endtask

    task automatic compare_all();
        bit exp_v;
        while (dq.size() > 0 && dq[0].due < e) void'(dq.pop_front());
        exp_v = dq.size() > 0 && dq[0].due == e;
        chk("phase", phase, m_phase);
        chk("x_out", x_out, m_x);
        chk("in_ready", in_ready, mq.size() < FD);
        chk("underrun", underrun, m_under);
        chk("underrun_cnt", underrun_cnt, m_ucnt);
        chk("med_valid", med_valid, exp_v);
        if (exp_v) begin
            chk("med_data", med_data, dq[0].val);
            void'(dq.pop_front());
        end
        if (med_valid === 1'b1) n_medv++;
        if (underrun === 1'b1) n_under_seen++;
        if (collect && phase === 1'b0 && underrun === 1'b0)
            seen.push_back(x_out);
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        if (reset) model_reset();
        else model_edge();
        #1 med_in = f(e);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        model_reset();
        #1 compare_all();
        chk("rst_med_data", med_data, '0);
        chk("rst_x_out", x_out, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic feed(input int base, input int n);
        int k = 0;
        int guard = 0;
        bit acc;
        while (k < n && guard < 20 * n + 50) begin
            in_valid = 1'b1;
            in_data  = DW'(base + k);
            acc = in_ready;
            step();
            if (acc) begin
                acc_q.push_back(DW'(base + k));
                k++;
            end
            guard++;
        end
        in_valid = 1'b0;
        chk("feed_done", k, n);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        vec_t          tab[7];
        bit            saw_low;
        bit            found;
        bit            rnd_acc;
        int            g;
        int            nxt;
        logic [DW-1:0] xh;
        logic [15:0]   ubase;

        tab[0] = '{1'b1, 16'd1, 1'b0, 16'd0, 1'b1};
        tab[1] = '{1'b1, 16'd2, 1'b1, 16'd0, 1'b1};
        tab[2] = '{1'b1, 16'd3, 1'b0, 16'd1, 1'b1};
        tab[3] = '{1'b1, 16'd4, 1'b1, 16'd1, 1'b1};
        tab[4] = '{1'b1, 16'd5, 1'b0, 16'd2, 1'b1};
        tab[5] = '{1'b1, 16'd6, 1'b1, 16'd2, 1'b1};
        tab[6] = '{1'b1, 16'd7, 1'b0, 16'd3, 1'b1};

        model_reset();
        med_in = f(0);
        step();
        step();
        reset = 1'b0;

        // Window fill: 20 samples back-to-back, a single median.
        n_medv = 0;
        for (int r = 0; r < 7; r++) begin
            chk("tab_phase", phase, tab[r].ph);
            chk("tab_x_out", x_out, tab[r].x);
            chk("tab_in_ready", in_ready, tab[r].rdy);
            in_valid = tab[r].v;
            in_data  = tab[r].d;
            step();
        end
        chk("tab_full_ready", in_ready, 1'b0);
        feed(8, 13);
        idle(60);
        chk("med_count_fill", n_medv, 1);

        // Continuous valid: ready drops, drained stream is loss-free.
        acc_q.delete();
        seen.delete();
        collect = 1'b1;
        saw_low = 1'b0;
        nxt = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(100 + nxt);
            found = in_ready;
            if (!in_ready) saw_low = 1'b1;
            step();
            if (found) begin
                acc_q.push_back(DW'(100 + nxt));
                nxt++;
            end
        end
        in_valid = 1'b0;
        idle(30);
        collect = 1'b0;
        chk("ready_dropped", saw_low, 1'b1);
        chk("stream_len", seen.size(), acc_q.size());
        for (int i = 0; i < seen.size() && i < acc_q.size(); i++)
            chk("stream_val", seen[i], acc_q[i]);

        // Two starved slots in RUN.
        if (phase === 1'b1) step();
        n_under_seen = 0;
        n_medv = 0;
        xh = m_x;
        ubase = m_ucnt;
        idle(4);
        chk("starve_pulses", n_under_seen, 2);
        chk("starve_medv", n_medv, 0);
        chk("starve_hold", x_out, xh);
`ifdef MEDIAN_FEEDER_UNDERRUN_CNT_EN
        chk("starve_cnt", underrun_cnt, ubase + 16'd2);
`else
        chk("starve_cnt", underrun_cnt, ubase);
`endif

        // Push into an empty FIFO on the phase-1 edge.
        g = 0;
        while (!(m_phase && mq.size() == 0) && g < 20) begin
            step();
            g++;
        end
        chk("late_setup", phase, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'hABCD;
        step();
        in_valid = 1'b0;
        chk("late_underrun", underrun, 1'b1);
        step();
        step();
        chk("late_x_out", x_out, 16'hABCD);
        chk("late_no_underrun", underrun, 1'b0);

        // Random traffic.
        rnd_acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || rnd_acc) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = DW'($urandom);
            end
            rnd_acc = in_valid && in_ready;
            step();
        end
        in_valid = 1'b0;
        idle(20);

        // Reset at phase 1 with three samples buffered.
        found = 1'b0;
        g = 0;
        while (!found && g < 50) begin
            in_valid = 1'b1;
            in_data  = DW'(200 + g);
            step();
            found = m_phase && mq.size() == 3;
            g++;
        end
        in_valid = 1'b0;
        chk("rst_setup", found, 1'b1);
        chk("rst_setup_phase", phase, 1'b1);
        do_reset();
        n_medv = 0;
        idle(6);
        chk("rst_no_medv", n_medv, 0);
        feed(300, 20);
        idle(60);
        chk("med_count_refill", n_medv, 1);

        // Long starvation: counter saturates or stays tied off.
`ifdef MEDIAN_FEEDER_UNDERRUN_CNT_EN
        idle(2 * 65537 + 4);
        chk("ucnt_sat", underrun_cnt, 16'hFFFF);
`else
        idle(40);
        chk("ucnt_off", underrun_cnt, 16'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
